mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-to-1 mux datapath among four requesters. Each requester holds its own request line for as long as it owns the mux. The arbiter drives the mux select pair `{s1,s0}` and a one-hot grant vector, and guarantees fair rotation. It sits directly in front of the mux select inputs; the mux data inputs `i0..i3` are wired to the four requesters' data.

---
 rtl/mux4_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving the select lines of a 4-to-1 mux
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       s0,
  output logic       s1,
  output logic       valid,
  output logic       preempt
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic [1:0] ptr_next;
  logic [2:0] pick_idle;
  logic [2:0] pick_rel;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  // Returns {found, index}; scanning offsets high-to-low lets the lowest offset from p win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // The owner is masked so the same search serves both a release and a forced release.
  always_comb begin
    ptr_next  = owner + 2'd1;
    pick_idle = rr_pick(req, ptr);
    pick_rel  = rr_pick(req & ~(4'b0001 << owner), ptr_next);
  end

  // The select pair is the owner register itself, so it keeps its last value while idle.
  assign s0 = owner[0];
  assign s1 = owner[1];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      owner   <= 2'd0;
      grant   <= 4'b0000;
      valid   <= 1'b0;
      preempt <= 1'b0;
      hold    <= 8'd0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_idle[2]) begin
            state <= OWN;
            owner <= pick_idle[1:0];
            grant <= 4'b0001 << pick_idle[1:0];
            valid <= 1'b1;
            hold  <= 8'd1;
          end
        end
        OWN: begin
          if (!req[owner]) begin
            ptr <= ptr_next;
            if (pick_rel[2]) begin
              owner <= pick_rel[1:0];
              grant <= 4'b0001 << pick_rel[1:0];
              hold  <= 8'd1;
            end else begin
              state <= IDLE;
              grant <= 4'b0000;
              valid <= 1'b0;
            end
          end else if (hold == 8'(MAX_HOLD)) begin
            ptr  <= ptr_next;
            hold <= 8'd1;
            if (pick_rel[2]) begin
              owner   <= pick_rel[1:0];
              grant   <= 4'b0001 << pick_rel[1:0];
              preempt <= 1'b1;
            end
          end else if (hold != 8'hFF) begin
            hold <= hold + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign preempt = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      owner <= 2'd0;
      grant <= 4'b0000;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[2]) begin
            state <= OWN;
            owner <= pick_idle[1:0];
            grant <= 4'b0001 << pick_idle[1:0];
            valid <= 1'b1;
          end
        end
        OWN: begin
          if (!req[owner]) begin
            ptr <= ptr_next;
            if (pick_rel[2]) begin
              owner <= pick_rel[1:0];
              grant <= 4'b0001 << pick_rel[1:0];
            end else begin
              state <= IDLE;
              grant <= 4'b0000;
              valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard bench for mux4_rr_arbiter (ARB_TIMEOUT_EN cases when defined)
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       s0, s1, valid, preempt;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  event chk_ev;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .s0(s0), .s1(s1), .valid(valid), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] s,
                            input logic v, input logic p);
    exp_t e;
    e.name = name; e.g = g; e.s = s; e.v = v; e.p = p;
    q.push_back(e);
  endtask

  // Drive req for the next edge and queue the outputs expected after it.
  task automatic cyc(input string name, input logic [3:0] r, input logic [3:0] g,
                     input logic [1:0] s, input logic v, input logic p);
    @(negedge clk);
    req = r;
    expect_out(name, g, s, v, p);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_chk++;
        if (grant !== e.g || {s1, s0} !== e.s || valid !== e.v || preempt !== e.p) begin
          n_fail++;
          $display("FAIL %s: got grant=%b sel=%b valid=%b preempt=%b, expected grant=%b sel=%b valid=%b preempt=%b",
                   e.name, grant, {s1, s0}, valid, preempt, e.g, e.s, e.v, e.p);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    req = 4'b1111;
    cyc("reset_hold", 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
    @(posedge clk); #3; rst_n = 1'b1;

    cyc("reset_release", 4'b1111, 4'b0001, 2'b00, 1'b1, 1'b0);
    cyc("rot_own0_b", 4'b1111, 4'b0001, 2'b00, 1'b1, 1'b0);
    cyc("rot_own0_c", 4'b1111, 4'b0001, 2'b00, 1'b1, 1'b0);
    cyc("rot_to1", 4'b1110, 4'b0010, 2'b01, 1'b1, 1'b0);
    cyc("rot_own1_b", 4'b1111, 4'b0010, 2'b01, 1'b1, 1'b0);
    cyc("rot_own1_c", 4'b1111, 4'b0010, 2'b01, 1'b1, 1'b0);
    cyc("rot_to2", 4'b1101, 4'b0100, 2'b10, 1'b1, 1'b0);
    cyc("rot_own2_b", 4'b1111, 4'b0100, 2'b10, 1'b1, 1'b0);
    cyc("rot_own2_c", 4'b1111, 4'b0100, 2'b10, 1'b1, 1'b0);
    cyc("rot_to3", 4'b1011, 4'b1000, 2'b11, 1'b1, 1'b0);
    cyc("rot_own3_b", 4'b1111, 4'b1000, 2'b11, 1'b1, 1'b0);
    cyc("rot_own3_c", 4'b1111, 4'b1000, 2'b11, 1'b1, 1'b0);
    cyc("rot_wrap_to0", 4'b0111, 4'b0001, 2'b00, 1'b1, 1'b0);
    cyc("release_idle", 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++)
      cyc("single_req2", 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0);
    cyc("single_drop", 4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0);

    cyc("wrap_skip_ptr3", 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b0);
    cyc("wrap_release_to1", 4'b0010, 4'b0010, 2'b01, 1'b1, 1'b0);
    cyc("idle_keep_sel", 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0);

    cyc("own3_before_reset", 4'b1000, 4'b1000, 2'b11, 1'b1, 1'b0);
    @(posedge clk); #3;
    expect_out("async_reset_no_clock", 4'b0000, 2'b00, 1'b0, 1'b0);
    req = 4'b0000;
    rst_n = 1'b0;
    #1 -> chk_ev;
    #2 rst_n = 1'b1;
    cyc("after_reset_ptr0", 4'b1010, 4'b0010, 2'b01, 1'b1, 1'b0);
    cyc("after_reset_idle", 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++)
      cyc("to_own0", 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b0);
    cyc("to_preempt_to1", 4'b0011, 4'b0010, 2'b01, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc("to_own1", 4'b0011, 4'b0010, 2'b01, 1'b1, 1'b0);
    cyc("to_preempt_to0", 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++)
      cyc("to_alone_keep", 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b0);
    cyc("to_release", 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
